spi_memory_fsm: RTL and testbench
=================================

Name: spi_memory_fsm

Overview:
Transaction controller for the SPI memory slave. It consumes the conditioned chip-select and the SCLK rising-edge pulse, and counts serial bits. It sequences the shift register parallel load, the address latch enable, the data memory write enable and the MISO tristate enable. One instance sits between the input conditioners and the shift-register/memory datapath. The frame is ADDR_WIDTH address bits (MSB first), then one R/W bit (1 = read), then DATA_WIDTH data bits.

Parameters:
ADDR_WIDTH, 7, address bits per frame
DATA_WIDTH, 8, data bits per frame; the shift register is DATA_WIDTH wide and the header is ADDR_WIDTH+1 = DATA_WIDTH bits

Ports:
clk  input  1  FPGA system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; forces IDLE immediately
cs  input  1  conditioned chip select, active low
sclk_posedge  input  1  single-clk pulse per SCLK rising edge, from the conditioner
rw_bit  input  1  shift register parallelDataOut[0]; valid the cycle after the header's last sclk_posedge
sr_load  output  1  shift register parallelLoad
addr_we  output  1  address latch enable
dm_we  output  1  data memory writeEnable
miso_en  output  1  MISO tristate buffer enable
bit_count  output  4  current bit counter, debug
state  output  3  encoded state for LEDs/debug

Behaviour:
- State encoding: IDLE=0, GET_HDR=1, GOT_HDR=2, READ_LOAD=3, READ_SHIFT=4, WRITE_GET=5, WRITE_COMMIT=6, DONE=7.
- Reset (async, any time, including mid-transaction): state=IDLE, bit_count=0, and sr_load, addr_we, dm_we and miso_en all 0. Registered state/counter outputs reflect these values immediately.
- All control outputs are decoded from registered state only (Moore): no combinational path from inputs to outputs.
- Global abort: cs=1 in any state -> next state IDLE with bit_count=0. This has priority over sclk_posedge in the same cycle. No write may occur after an abort, including from WRITE_COMMIT's successor.
- IDLE: outputs 0. cs=0 -> GET_HDR, bit_count=0.
- GET_HDR: each sclk_posedge increments bit_count. A sclk_posedge arriving with bit_count=DATA_WIDTH-1 -> GOT_HDR with bit_count cleared.
- GOT_HDR (1 cycle): addr_we=1, latching the shift register contents (address in the upper bits). Next state: rw_bit=1 -> READ_LOAD, rw_bit=0 -> WRITE_GET.
- READ_LOAD (1 cycle): sr_load=1. The memory output for the just-latched address is loaded into the shift register. Next state -> READ_SHIFT.
- READ_SHIFT: miso_en=1. Each sclk_posedge increments bit_count. The DATA_WIDTH-th sclk_posedge -> DONE, bit_count cleared.
- WRITE_GET: each sclk_posedge increments bit_count. The DATA_WIDTH-th sclk_posedge -> WRITE_COMMIT, bit_count cleared.
- WRITE_COMMIT (1 cycle): dm_we=1, exactly one clk. Next state -> DONE.
- DONE: outputs 0. sclk_posedge is ignored and the counter is held. The FSM stays in DONE until cs=1, then goes to IDLE. A new transaction requires a cs high-then-low.
- sclk_posedge during GOT_HDR, READ_LOAD or WRITE_COMMIT is ignored. The master guarantees an SCLK half-period of at least 4 clk.
- bit_count never exceeds DATA_WIDTH-1 and never wraps. Width is 4 bits; values at or above DATA_WIDTH are unreachable.
- Latency: addr_we asserts 1 clk after the header's last sclk_posedge. For a write, dm_we asserts 1 clk after the data's last sclk_posedge.

Test Plan:
- Reset: assert reset mid-READ_SHIFT asynchronously (between clk edges) -> state=0, miso_en=0, bit_count=0 before the next clk edge; after release with cs=0 held, the FSM enters GET_HDR on the first clk edge and waits for sclk_posedge.
- Write frame: cs=0, 8 sclk_posedge pulses with rw_bit=0 at GOT_HDR, then 8 more pulses -> addr_we high exactly 1 clk after the 8th pulse; dm_we high exactly 1 clk, 1 clk after the 16th pulse; sr_load and miso_en never high; state ends at 7.
- Read frame: header with rw_bit=1 -> addr_we 1 clk, then sr_load 1 clk on the next cycle, then miso_en=1 for the whole span until 1 clk after the 16th pulse; dm_we never high; final state=7.
- Abort: cs rises after the 12th pulse of a write -> state=0 next clk, dm_we never asserted, bit_count=0.
- Simultaneous events: cs=1 and sclk_posedge in the same cycle with bit_count=7 in GET_HDR -> IDLE, GOT_HDR never entered, addr_we never high.
- Extra clocks: 4 additional sclk_posedge pulses in DONE -> state stays 7 and outputs stay 0; cs=1 -> IDLE; a new cs=0 frame completes normally.

Source files
------------

// File: rtl/spi_memory_fsm.sv
// Transaction controller for the SPI memory slave: counts serial bits and
// sequences shift-register load, address latch, memory write and MISO enable.
module spi_memory_fsm #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       sclk_posedge,
  input  logic       rw_bit,
  output logic       sr_load,
  output logic       addr_we,
  output logic       dm_we,
  output logic       miso_en,
  output logic [3:0] bit_count,
  output logic [2:0] state
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] GET_HDR      = 3'd1;
  localparam logic [2:0] GOT_HDR      = 3'd2;
  localparam logic [2:0] READ_LOAD    = 3'd3;
  localparam logic [2:0] READ_SHIFT   = 3'd4;
  localparam logic [2:0] WRITE_GET    = 3'd5;
  localparam logic [2:0] WRITE_COMMIT = 3'd6;
  localparam logic [2:0] DONE         = 3'd7;

  localparam int         HDR_BITS  = ADDR_WIDTH + 1;
  localparam logic [3:0] HDR_LAST  = 4'(HDR_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_WIDTH - 1);

  logic [2:0] state_q, state_d;
  logic [3:0] bit_count_q, bit_count_d;

  always_comb begin
    state_d     = state_q;
    bit_count_d = bit_count_q;
    // Chip-select deassertion aborts from every state and beats sclk_posedge.
    if (cs) begin
      state_d     = IDLE;
      bit_count_d = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d     = GET_HDR;
          bit_count_d = 4'd0;
        end
        GET_HDR: begin
          if (sclk_posedge) begin
            if (bit_count_q == HDR_LAST) begin
              state_d     = GOT_HDR;
              bit_count_d = 4'd0;
            end else begin
              bit_count_d = bit_count_q + 4'd1;
            end
          end
        end
        GOT_HDR:   state_d = rw_bit ? READ_LOAD : WRITE_GET;
        READ_LOAD: state_d = READ_SHIFT;
        READ_SHIFT, WRITE_GET: begin
          if (sclk_posedge) begin
            if (bit_count_q == DATA_LAST) begin
              state_d     = (state_q == READ_SHIFT) ? DONE : WRITE_COMMIT;
              bit_count_d = 4'd0;
            end else begin
              bit_count_d = bit_count_q + 4'd1;
            end
          end
        end
        WRITE_COMMIT: state_d = DONE;
        DONE:         state_d = DONE;
        default: begin
          state_d     = IDLE;
          bit_count_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_count_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      bit_count_q <= bit_count_d;
    end
  end

  // Moore decode: every control output depends on registered state only.
  assign sr_load   = (state_q == READ_LOAD);
  assign addr_we   = (state_q == GOT_HDR);
  assign dm_we     = (state_q == WRITE_COMMIT);
  assign miso_en   = (state_q == READ_SHIFT);
  assign bit_count = bit_count_q;
  assign state     = state_q;

endmodule

// File: tb/tb_spi_memory_fsm.sv
// Randomized self-checking bench for spi_memory_fsm, compared cycle by cycle
// against a pulse-count/elapsed-time model of an SPI frame.
module tb_spi_memory_fsm;

  localparam int HDR   = 8;
  localparam int FRAME = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cs = 1'b1;
  logic       sclk_posedge = 1'b0;
  logic       rw_bit = 1'b0;
  logic       sr_load, addr_we, dm_we, miso_en;
  logic [3:0] bit_count;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  // Frame model: accepted pulses since frame start and edges elapsed since
  // the header / data completed.
  bit mActive = 0;
  bit mIsRead = 0;
  int mPulses = 0;
  int mSinceHdr = 0;
  int mSinceData = 0;

  spi_memory_fsm #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .cs(cs),
    .sclk_posedge(sclk_posedge),
    .rw_bit(rw_bit),
    .sr_load(sr_load),
    .addr_we(addr_we),
    .dm_we(dm_we),
    .miso_en(miso_en),
    .bit_count(bit_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelEdge(input logic csS, input logic sclkS, input logic rwS);
    if (reset || csS) begin
      mActive = 0;
      mPulses = 0;
    end else if (!mActive) begin
      mActive = 1;
      mPulses = 0;
      mSinceHdr = 0;
      mSinceData = 0;
    end else if (mPulses < HDR) begin
      if (sclkS) begin
        mPulses++;
        if (mPulses == HDR) mSinceHdr = 0;
      end
    end else if (mPulses < FRAME) begin
      if (mSinceHdr == 0) mIsRead = rwS;
      else if (sclkS && mSinceHdr >= (mIsRead ? 2 : 1)) begin
        mPulses++;
        if (mPulses == FRAME) mSinceData = 0;
      end
      if (mSinceHdr < 100) mSinceHdr++;
    end else begin
      if (mSinceData < 100) mSinceData++;
    end
  endtask

  task automatic checkAll(input string tag);
    logic [2:0] expState;
    logic [3:0] expCount;
    expCount = 4'd0;
    if (!mActive) expState = 3'd0;
    else if (mPulses < HDR) begin
      expState = 3'd1;
      expCount = 4'(mPulses);
    end else if (mPulses < FRAME) begin
      if (mSinceHdr == 0) expState = 3'd2;
      else if (mIsRead && mSinceHdr == 1) expState = 3'd3;
      else begin
        expState = mIsRead ? 3'd4 : 3'd5;
        expCount = 4'(mPulses - HDR);
      end
    end else begin
      expState = (!mIsRead && mSinceData == 0) ? 3'd6 : 3'd7;
    end
    checkOutput({tag, ".state"}, {1'b0, state}, {1'b0, expState});
    checkOutput({tag, ".bit_count"}, bit_count, expCount);
    checkOutput({tag, ".sr_load"}, {3'b0, sr_load}, {3'b0, expState == 3'd3});
    checkOutput({tag, ".addr_we"}, {3'b0, addr_we}, {3'b0, expState == 3'd2});
    checkOutput({tag, ".dm_we"}, {3'b0, dm_we}, {3'b0, expState == 3'd6});
    checkOutput({tag, ".miso_en"}, {3'b0, miso_en}, {3'b0, expState == 3'd4});
  endtask

  // One clk cycle: drive inputs, advance the model at the edge, check 1 ns later.
  task automatic applyStimulus(input logic csV, input logic sclkV, input logic rwV, input string tag);
    cs = csV;
    sclk_posedge = sclkV;
    rw_bit = rwV;
    @(posedge clk);
    modelEdge(csV, sclkV, rwV);
    #1;
    checkAll(tag);
  endtask

  task automatic runFrame(input logic rwV, input int abortAfter, input logic abortWithPulse, input int extra);
    bit aborted = 0;
    applyStimulus(1'b0, 1'b0, rwV, "start");
    for (int p = 1; p <= FRAME + extra; p++) begin
      int gap = $urandom_range(4, 9);
      for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, rwV, "gap");
      if (p == abortAfter) begin
        if (abortWithPulse) applyStimulus(1'b1, 1'b1, rwV, "abort_pulse");
        else begin
          applyStimulus(1'b0, 1'b1, rwV, "pulse");
          applyStimulus(1'b0, 1'b0, rwV, "gap");
          applyStimulus(1'b1, 1'b0, rwV, "abort");
        end
        aborted = 1;
        break;
      end
      applyStimulus(1'b0, 1'b1, rwV, "pulse");
    end
    if (!aborted) for (int g = 0; g < 3; g++) applyStimulus(1'b0, 1'b0, rwV, "hold");
    for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, rwV, "idle");
  endtask

  task automatic resetMidRead();
    applyStimulus(1'b0, 1'b0, 1'b1, "rst_start");
    for (int p = 1; p <= 12; p++) begin
      for (int g = 0; g < 5; g++) applyStimulus(1'b0, 1'b0, 1'b1, "rst_gap");
      applyStimulus(1'b0, 1'b1, 1'b1, "rst_pulse");
    end
    sclk_posedge = 1'b0;
    #3 reset = 1'b1;
    #1;
    modelEdge(1'b0, 1'b0, 1'b1);
    checkAll("rst_async");
    @(posedge clk);
    #1 checkAll("rst_held");
    @(negedge clk) reset = 1'b0;
    for (int g = 0; g < 4; g++) applyStimulus(1'b0, 1'b0, 1'b1, "rst_release");
    for (int g = 0; g < 3; g++) applyStimulus(1'b1, 1'b0, 1'b1, "rst_idle");
  endtask

  initial begin
    #1;
    modelEdge(1'b1, 1'b0, 1'b0);
    checkAll("reset");
    @(negedge clk) reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, "idle");
    runFrame(1'b0, 0, 1'b0, 0);
    runFrame(1'b1, 0, 1'b0, 0);
    runFrame(1'b0, 12, 1'b0, 0);
    runFrame(1'b0, HDR, 1'b1, 0);
    runFrame(1'b1, 0, 1'b0, 4);
    resetMidRead();
    runFrame(1'b0, 0, 1'b0, 0);
    for (int f = 0; f < 20; f++) begin
      int abortAt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, FRAME) : 0;
      runFrame(1'($urandom_range(0, 1)), abortAt, 1'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
